// File: rtl/iter_alu.sv
// iter_alu: registered ALU with single-cycle logic/arith/shift ops and
// iterative (one bit per cycle) multiply, divide and remainder.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   start     - operation request, accepted in IDLE or DONE only
//   A, B      - operands (WIDTH bits, treated as signed where relevant)
//   ALUOp     - 4-bit operation code
//   ALUResult - registered result, updated only on the edge that raises done
//   Zero      - registered, 1 iff ALUResult == 0
//   busy      - high while an iterative operation runs
//   done      - one-cycle pulse when ALUResult is valid
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_SLT   = 4'd4;
    localparam logic [3:0] OP_SLTU  = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REM   = 4'd14;
    localparam logic [3:0] OP_REMU  = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]         op_q, op_d;
    // Multiply: {high partial sum, remaining multiplier/low product}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;

    // ---------------- single-cycle datapath (uses live inputs) ----------
    logic [WIDTH-1:0] single_res;
    logic [SHW-1:0]   shamt;

    assign shamt = B[SHW-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        single_res = '0;
        case (ALUOp)
            OP_ADD:  single_res = A + B;
            OP_SUB:  single_res = A - B;
            OP_AND:  single_res = A & B;
            OP_OR:   single_res = A | B;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_XOR:  single_res = A ^ B;
            OP_SLL:  single_res = A << shamt;
            OP_SRL:  single_res = A >> shamt;
            OP_SRA:  single_res = $signed(A) >>> shamt;
            default: single_res = '0;
        endcase
    end

    // ---------------- iterative datapath (uses latched operands) --------
    logic             in_iter, in_signed_div, in_is_mul;
    logic [WIDTH-1:0] in_a_mag;

    assign in_iter       = (ALUOp >= OP_MUL);
    assign in_is_mul     = (ALUOp == OP_MUL) || (ALUOp == OP_MULHU);
    assign in_signed_div = (ALUOp == OP_DIV) || (ALUOp == OP_REM);
    assign in_a_mag      = (in_signed_div && A[WIDTH-1]) ? -A : A;

    logic               is_mul, signed_div;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, acc_next;
    logic [WIDTH-1:0]   quo, rmd, iter_res;

    assign is_mul     = (op_q == OP_MUL) || (op_q == OP_MULHU);
    assign signed_div = (op_q == OP_DIV) || (op_q == OP_REM);
    assign b_mag      = (signed_div && b_q[WIDTH-1]) ? -b_q : b_q;

    // Shift-add: add A into the high half when the current multiplier bit
    // is set, then shift the whole accumulator right by one.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){acc_q[0]}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring division: shift the next dividend bit into the remainder and
    // subtract the divisor only if it does not go negative.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, b_mag};
    assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    assign acc_next = is_mul ? mul_next : div_next;
    assign quo      = acc_next[WIDTH-1:0];
    assign rmd      = acc_next[2*WIDTH-1:WIDTH];

    always_comb begin
        iter_res = '0;
        case (op_q)
            OP_MUL:   iter_res = acc_next[WIDTH-1:0];
            OP_MULHU: iter_res = acc_next[2*WIDTH-1:WIDTH];
            // Unsigned division by zero already yields all-ones; the signed
            // form needs an override so the sign fix-up cannot flip it.
            OP_DIV:   iter_res = (b_q == '0) ? '1
                               : ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo : quo);
            OP_DIVU:  iter_res = quo;
            OP_REM:   iter_res = a_q[WIDTH-1] ? -rmd : rmd;
            OP_REMU:  iter_res = rmd;
            default:  iter_res = '0;
        endcase
    end

    // ---------------- control ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    if (in_iter) begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = ALUOp;
                        cnt_d   = '0;
                        acc_d   = in_is_mul ? {{WIDTH{1'b0}}, B} : {{WIDTH{1'b0}}, in_a_mag};
                        state_d = S_RUN;
                    end else begin
                        res_d   = single_res;
                        zero_d  = (single_res == '0);
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                acc_d = acc_next;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1)) begin
                    res_d   = iter_res;
                    zero_d  = (iter_res == '0);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    // NOTE: operand and accumulator registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        op_q  <= op_d;
        acc_q <= acc_d;
    end

    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule
